// File: rtl/ntt_addr_sched.sv
// rtl/ntt_addr_sched.sv - in-place radix-2 forward NTT read/twiddle/write-back address scheduler
module ntt_addr_sched #(
  parameter int LOG_N  = 4,
  parameter int PE_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b,
  output logic [LOG_N-1:0] stage
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LOG_N-1:0] ONE      = LOG_N'(1);
  localparam logic [LOG_N-1:0] LAST_STG = LOG_N'(LOG_N - 1);
  localparam logic [LOG_N-2:0] J_MAX    = '1;
  localparam logic [3:0]       DRAIN_MID  = 4'(PE_LAT - 1);
  localparam logic [3:0]       DRAIN_LAST = 4'(PE_LAT);

  logic [1:0]       state;
  logic [LOG_N-2:0] j;
  logic [3:0]       dcnt;

  logic [PE_LAT-1:0] pv;
  logic [LOG_N-1:0]  pa [PE_LAT];
  logic [LOG_N-1:0]  pb [PE_LAT];

  logic [LOG_N-1:0] jx, half, kx, ax, bx, sh, twx;

  // Butterfly j of the current stage: group base plus offset within the group.
  always_comb begin
    jx   = {1'b0, j};
    half = ONE << stage;
    kx   = jx & (half - ONE);
    ax   = ((jx >> stage) << (stage + ONE)) | kx;
    bx   = ax + half;
    sh   = LAST_STG - stage;
    twx  = kx << sh;
  end

  assign wr_en     = pv[PE_LAT-1];
  assign wr_addr_a = pa[PE_LAT-1];
  assign wr_addr_b = pb[PE_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      stage     <= '0;
      j         <= '0;
      dcnt      <= '0;
      pv        <= '0;
      for (int i = 0; i < PE_LAT; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv[0] <= rd_en;
      pa[0] <= rd_addr_a;
      pb[0] <= rd_addr_b;
      for (int i = 1; i < PE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ISSUE;
            busy  <= 1'b1;
            stage <= '0;
            j     <= '0;
          end
        end
        S_ISSUE: begin
          rd_en <= !hold;
          if (!hold) begin
            rd_addr_a <= ax;
            rd_addr_b <= bx;
            tw_addr   <= twx[LOG_N-2:0];
            if (j == J_MAX) begin
              state <= S_DRAIN;
              dcnt  <= '0;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          rd_en <= 1'b0;
          // The final stage waits one more cycle so done follows the last write.
          if (stage != LAST_STG && dcnt == DRAIN_MID) begin
            state <= S_ISSUE;
            stage <= stage + ONE;
            j     <= '0;
          end else if (stage == LAST_STG && dcnt == DRAIN_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_addr_sched.sv
// tb/tb_ntt_addr_sched.sv - scoreboard bench for ntt_addr_sched
module tb_ntt_addr_sched;
  localparam int LOG_N  = 4;
  localparam int PE_LAT = 3;
  localparam int NB     = 8;

  logic             clk = 1'b0;
  logic             reset, start, hold;
  logic             busy, done, rd_en, wr_en;
  logic [LOG_N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
  logic [LOG_N-2:0] tw_addr;

  ntt_addr_sched #(.LOG_N(LOG_N), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int a; int b; int tw; int st; } rd_t;
  typedef struct { int a; int b; int st; int due; } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  rd_t obs[$];
  int  obs_cyc[$];
  int  n_wr = 0;
  int  tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rd_t model(input int s, input int jj);
    rd_t r;
    int h, k, g;
    h = 1 << s;
    k = jj % h;
    g = jj / h;
    r.a  = g * 2 * h + k;
    r.b  = r.a + h;
    r.tw = k * (1 << (LOG_N - 1 - s));
    r.st = s;
    return r;
  endfunction

  task automatic push_run();
    for (int s = 0; s < LOG_N; s++)
      for (int jj = 0; jj < NB; jj++)
        rd_q.push_back(model(s, jj));
  endtask

  // Monitor: reads pop the expected sequence, writes pop what reads scheduled.
  rd_t me, mo;
  wr_t mw;
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        me = rd_q.pop_front();
        chk("rd_addr_a", int'(rd_addr_a), me.a);
        chk("rd_addr_b", int'(rd_addr_b), me.b);
        chk("tw_addr", int'(tw_addr), me.tw);
        chk("rd_stage", int'(stage), me.st);
        if (obs.size() > 0 && obs[obs.size()-1].st != me.st)
          chk("stage_read_before_prev_writes", wr_q.size(), 0);
        mo.a = int'(rd_addr_a); mo.b = int'(rd_addr_b);
        mo.tw = int'(tw_addr); mo.st = int'(stage);
        obs.push_back(mo);
        obs_cyc.push_back(cyc);
        wr_q.push_back('{a: me.a, b: me.b, st: me.st, due: cyc + PE_LAT});
      end
    end
    if (wr_en === 1'b1) begin
      n_wr++;
      if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        mw = wr_q.pop_front();
        chk("wr_addr_a", int'(wr_addr_a), mw.a);
        chk("wr_addr_b", int'(wr_addr_b), mw.b);
        chk("wr_cycle", cyc, mw.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int s_edge, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin
        lat = cyc - s_edge;
        break;
      end
      tick();
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_reads(input int n);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (obs.size() >= n) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (ok == 0) chk("read_count_timeout", obs.size(), n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_stage"}, int'(stage), 0);
    chk({tag, "_rd_addr"}, int'({rd_addr_a, rd_addr_b, tw_addr}), 0);
    chk({tag, "_wr_addr"}, int'({wr_addr_a, wr_addr_b}), 0);
  endtask

  int s_edge, lat, wr_base;

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    start = 1'b1;
    tick();
    chk("reset_beats_start", int'(busy), 0);
    reset = 1'b0; start = 1'b0;
    tick();

    // Run 1: plain transform, stray start mid-run, start during the done cycle.
    push_run();
    wr_base = n_wr;
    start = 1'b1; s_edge = cyc + 1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(s_edge, lat);
    chk("latency_run1", lat, 45);
    chk("busy_in_done", int'(busy), 1);
    chk("run1_reads", obs.size(), 32);
    chk("run1_writes", n_wr - wr_base, 32);
    if (obs.size() == 32) begin
      chk("r0_a", obs[0].a, 0);  chk("r0_b", obs[0].b, 1);  chk("r0_tw", obs[0].tw, 0);
      chk("r1_a", obs[1].a, 2);  chk("r1_b", obs[1].b, 3);
      chk("s1j1_a", obs[9].a, 1); chk("s1j1_b", obs[9].b, 3); chk("s1j1_tw", obs[9].tw, 4);
      chk("s3j7_a", obs[31].a, 7); chk("s3j7_b", obs[31].b, 15); chk("s3j7_tw", obs[31].tw, 7);
      chk("drain_gap", obs_cyc[8] - obs_cyc[7], 4);
      chk("stage_after_drain", obs[8].st, 1);
    end
    start = 1'b1;
    tick();
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);

    // Run 2: start held into the cycle after done; hold 5 cycles at stage 2 j=3.
    obs.delete(); obs_cyc.delete();
    push_run();
    wr_base = n_wr;
    s_edge = cyc + 1;
    tick();
    start = 1'b0;
    chk("start_after_done_accepted", int'(busy), 1);
    wait_reads(18);
    hold = 1'b1;
    repeat (5) tick();
    hold = 1'b0;
    wait_done(s_edge, lat);
    chk("latency_hold", lat, 50);
    chk("run2_reads", obs.size(), 32);
    chk("run2_writes", n_wr - wr_base, 32);
    if (obs.size() == 32) begin
      chk("resume_a", obs[19].a, 3); chk("resume_b", obs[19].b, 7); chk("resume_tw", obs[19].tw, 6);
      chk("hold_gap", obs_cyc[19] - obs_cyc[18], 6);
    end
    repeat (3) tick();

    // Run 3: reset in the stage-1 drain window.
    obs.delete(); obs_cyc.delete();
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_reads(16);
    reset = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    rd_q.delete(); wr_q.delete();
    wr_base = n_wr;
    repeat (10) tick();
    chk("writes_after_reset", n_wr - wr_base, 0);

    // Run 4: full transform after the abort.
    obs.delete(); obs_cyc.delete();
    push_run();
    wr_base = n_wr;
    start = 1'b1; s_edge = cyc + 1;
    tick();
    start = 1'b0;
    wait_done(s_edge, lat);
    chk("latency_after_reset", lat, 45);
    chk("run4_writes", n_wr - wr_base, 32);
    tick();
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
